rr_grant_sequencer: RTL and testbench
=====================================

// Module: rr_grant_sequencer
// PURPOSE
//  Round-robin arbiter/sequencer for a 3-to-8 decoded shared resource.
//  - Up to 8 requesters compete for the resource.
//  - Selects one requester and drives its 3-bit index plus the decoded one-hot grant.
//  - Holds the grant until the owner releases it or a hold timeout expires.
//  - Sits between the requesting units and the decoder-selected resource.
// PARAMETERS
//  MAX_HOLD  16  max cycles one grant may persist; 0 disables timeout
//  CNT_W     5   hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk          in   1  rising-edge clock
//  reset_n      in   1  asynchronous active-low reset
//  req          in   8  request lines; req[i] high = requester i wants the resource
//  done         in   1  owner release strobe; honoured only in GRANT
//  grant        out  8  one-hot grant; all zero when nothing is granted
//  grant_id     out  3  index of current owner; valid while grant_valid=1
//  grant_valid  out  1  a grant is active
//  timeout      out  1  one-cycle pulse when a grant is force-released
// BEHAVIOUR
//  - One clock, asynchronous active-low reset; single state register (IDLE, GRANT).
//  - Reset, applied asynchronously at any time including mid-grant:
//    - grant=0, grant_id=0, grant_valid=0, timeout=0.
//    - state=IDLE, rotate pointer ptr=0, hold counter=0.
//  - IDLE:
//    - If |req at a rising edge: go to GRANT on that edge.
//    - Winner = first i with req[i]=1, searching ptr, ptr+1, ..., ptr+7 mod 8.
//    - grant_id=winner, grant_valid=1, counter=0.
//    - Latency: req sampled at edge k -> grant visible after edge k.
//    - done is ignored in IDLE.
//  - GRANT: req is ignored; the grant is held and the counter increments each cycle.
//    - done=1 at an edge -> IDLE on that edge, grant_valid=0, ptr=(grant_id+1) mod 8.
//    - MAX_HOLD>0, done=0 and counter==MAX_HOLD-1 -> same release, plus timeout=1 for one cycle.
//    - done and the timeout condition in the same cycle -> normal release, timeout stays 0.
//  - Grant duration:
//    - Without done, the grant is visible for exactly MAX_HOLD cycles.
//    - With MAX_HOLD=0 it is held indefinitely until done.
//  - Gap between grants: at least one IDLE cycle (grant=0) between consecutive grants.
//  - ptr wrap-around: 7+1 -> 0 (3-bit arithmetic, carry discarded).
//  - ptr changes only on release; an IDLE cycle with no request leaves it unchanged.
//  - grant = grant_valid ? (8'b1 << grant_id) : 8'b0, combinationally decoded from registered
//    grant_id/grant_valid. The outputs are therefore glitch-free with respect to req.
//  - timeout is registered and is 0 in every cycle except the release cycle after a forced release.
// STRUCTURE
//  - Shared include rr_arb_defs.vh:
//    - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
//    - NREQ=8, ID_W=3.
//  - Sub-module rr_pick (combinational): inputs req[7:0] and ptr[2:0]; outputs found and
//    idx[2:0]. Implements the rotate/priority-search/rotate-back.
//  - Top level holds the state register, ptr, hold counter, output registers and grant decode.
// TESTING
//  1. reset_n=0 with req=8'hFF, clock running -> grant=0, grant_valid=0, grant_id=0, timeout=0.
//  2. After reset, req=8'h04 for one cycle, done pulse 2 cycles later
//     -> grant=8'h04 and grant_id=2 after the first edge; grant=0 the edge after done.
//  3. req=8'hFF held, done asserted in every GRANT cycle
//     -> grant_id sequence 0,1,...,7,0 with one idle cycle between grants.
//  4. After granting id 6, req=8'h81 held with done pulses -> grant_id 7, then 0 (ptr wrap).
//  5. MAX_HOLD=4, req=8'h08 held, done=0 -> grant=8'h08 for 4 cycles;
//     then grant=0, timeout=1 for one cycle, and the next grant goes to id 3 again
//     (only requester), searched from ptr=4.
//  6. reset_n dropped mid-grant between clock edges -> grant, grant_valid and timeout go to 0
//     without a clock edge; the first grant after release goes to the lowest requester from ptr=0.

Source files
------------

// File: rtl/rr_grant_sequencer_pkg.sv
// Shared types and constants for the round-robin grant sequencer.
// Imported by the interface, the priority picker and the top level.
package rr_grant_sequencer_pkg;

  localparam int NREQ = 8;
  localparam int ID_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Turns an owner index into the one-hot select for the shared resource.
  function automatic logic [NREQ-1:0] decode_id(input logic [ID_W-1:0] id);
    logic [NREQ-1:0] onehot;
    onehot = '0;
    onehot[id] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/rr_grant_sequencer_if.sv
// Request/grant bundle between the requesting units and the arbiter.
// master = requester side, slave = arbiter side.
interface rr_grant_sequencer_if;
  import rr_grant_sequencer_pkg::*;

  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_id;
  logic            grant_valid;
  logic            timeout;

  modport master (
    output req, done,
    input  grant, grant_id, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_id, grant_valid, timeout
  );

endinterface

// File: rtl/rr_grant_sequencer_pick.sv
// Round-robin priority search: the first set request at or after ptr,
// wrapping modulo NREQ, found by rotate / lowest-bit search / rotate back.
module rr_pick
  import rr_grant_sequencer_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  logic [2*NREQ-1:0] doubled;
  logic [NREQ-1:0]   rotated;
  logic [ID_W-1:0]   offset;

  assign doubled = {req, req};
  assign rotated = doubled[{1'b0, ptr} +: NREQ];

  // Scanning downwards lets the lowest set bit of the rotated vector win.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = ID_W'(i);
      end
    end
  end

  assign idx = ptr + offset;

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter for a decoder-selected shared resource: grants one
// requester at a time and holds it until done or the hold timeout.
module rr_grant_sequencer
  import rr_grant_sequencer_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rr_grant_sequencer_if.slave  bus
);

  localparam bit               TIMEOUT_EN = (MAX_HOLD > 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t           state, state_n;
  logic [ID_W-1:0]  ptr, ptr_n;
  logic [ID_W-1:0]  id_q, id_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             timeout_q, timeout_n;

  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic             hold_expired;

  rr_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign hold_expired = TIMEOUT_EN && (cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      id_q      <= '0;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      id_q      <= id_n;
      cnt       <= cnt_n;
      timeout_q <= timeout_n;
    end
  end

  // A simultaneous done wins over the timeout, so timeout only flags forced releases.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    id_n      = id_q;
    cnt_n     = cnt;
    timeout_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_n = ST_GRANT;
          id_n    = pick_idx;
          cnt_n   = '0;
        end
      end
      ST_GRANT: begin
        if (bus.done || hold_expired) begin
          state_n   = ST_IDLE;
          ptr_n     = id_q + ID_W'(1);
          cnt_n     = '0;
          timeout_n = !bus.done;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  assign bus.grant_valid = (state == ST_GRANT);
  assign bus.grant_id    = id_q;
  assign bus.timeout     = timeout_q;
  assign bus.grant       = (state == ST_GRANT) ? decode_id(id_q) : '0;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed plus randomized bench for rr_grant_sequencer, checked against a
// cycle-level behavioural model of the round-robin grant rules.
module tb_rr_grant_sequencer;
  import rr_grant_sequencer_pkg::*;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  // Model: who owns the resource, how many cycles it has been visible,
  // where the next search starts, and whether the last release was forced.
  bit   m_busy;
  int   m_owner;
  int   m_ptr;
  int   m_age;
  bit   m_to;
  bit   m_fresh;

  rr_grant_sequencer_if bus();

  rr_grant_sequencer #(.MAX_HOLD(HOLD), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_age   = 0;
    m_to    = 1'b0;
    m_fresh = 1'b1;
  endtask

  task automatic model_release(input bit forced);
    m_busy = 1'b0;
    m_ptr  = (m_owner + 1) % NREQ;
    m_to   = forced;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    m_to = 1'b0;
    if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!m_busy && r[(m_ptr + k) % NREQ]) begin
          m_busy  = 1'b1;
          m_owner = (m_ptr + k) % NREQ;
          m_age   = 1;
          m_fresh = 1'b0;
        end
      end
    end else if (d) begin
      model_release(1'b0);
    end else if (HOLD > 0 && m_age == HOLD) begin
      model_release(1'b1);
    end else begin
      m_age++;
    end
  endtask

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_output(input string tag);
    logic [7:0] eg;
    eg = m_busy ? 8'(1 << m_owner) : 8'h00;
    n_assert++;
    assert (bus.grant === eg) else begin
      n_fail++;
      $error("[TB] FAIL %s grant: observed %h expected %h", tag, bus.grant, eg);
    end
    n_assert++;
    assert (bus.grant_valid === m_busy) else begin
      n_fail++;
      $error("[TB] FAIL %s grant_valid: observed %b expected %b", tag, bus.grant_valid, m_busy);
    end
    n_assert++;
    assert (bus.timeout === m_to) else begin
      n_fail++;
      $error("[TB] FAIL %s timeout: observed %b expected %b", tag, bus.timeout, m_to);
    end
    if (m_busy || m_fresh) begin
      n_assert++;
      assert (bus.grant_id === 3'(m_owner)) else begin
        n_fail++;
        $error("[TB] FAIL %s grant_id: observed %0d expected %0d", tag, bus.grant_id, m_owner);
      end
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic [7:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    if (reset_n) model_edge(r, d);
    #1;
    check_output(tag);
  endtask

  // Asynchronous reset between clock edges, released on the following negedge.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_output(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    bus.req  = 8'hFF;
    bus.done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset");
    check_value("reset_grant", 32'(bus.grant), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] single request and done release");
    apply_stimulus("t2_req", 8'h04, 1'b0);
    check_value("t2_grant", 32'(bus.grant), 32'h04);
    check_value("t2_id", 32'(bus.grant_id), 32'd2);
    apply_stimulus("t2_hold", 8'h00, 1'b0);
    apply_stimulus("t2_done", 8'h00, 1'b1);
    check_value("t2_released", 32'(bus.grant), 32'h0);
    apply_stimulus("t2_idle", 8'h00, 1'b0);

    $display("[TB] full rotation with done held");
    async_reset("t3_reset");
    for (int i = 0; i < 9; i++) begin
      apply_stimulus("t3_grant", 8'hFF, 1'b1);
      check_value("t3_id", 32'(bus.grant_id), 32'(i % 8));
      apply_stimulus("t3_gap", 8'hFF, 1'b1);
      check_value("t3_gap_grant", 32'(bus.grant), 32'h0);
    end

    $display("[TB] pointer wrap");
    apply_stimulus("t4_g6", 8'h40, 1'b0);
    check_value("t4_id6", 32'(bus.grant_id), 32'd6);
    apply_stimulus("t4_rel6", 8'h40, 1'b1);
    apply_stimulus("t4_g7", 8'h81, 1'b1);
    check_value("t4_id7", 32'(bus.grant_id), 32'd7);
    apply_stimulus("t4_rel7", 8'h81, 1'b1);
    apply_stimulus("t4_g0", 8'h81, 1'b1);
    check_value("t4_id0", 32'(bus.grant_id), 32'd0);
    apply_stimulus("t4_rel0", 8'h81, 1'b1);

    $display("[TB] hold timeout");
    async_reset("t5_reset");
    for (int i = 0; i < HOLD; i++) begin
      apply_stimulus("t5_hold", 8'h08, 1'b0);
      check_value("t5_grant", 32'(bus.grant), 32'h08);
    end
    apply_stimulus("t5_expire", 8'h08, 1'b0);
    check_value("t5_gap", 32'(bus.grant), 32'h0);
    check_value("t5_timeout", 32'(bus.timeout), 32'h1);
    apply_stimulus("t5_regrant", 8'h08, 1'b0);
    check_value("t5_regrant_id", 32'(bus.grant_id), 32'd3);
    check_value("t5_timeout_clear", 32'(bus.timeout), 32'h0);
    apply_stimulus("t5_rel", 8'h00, 1'b1);

    $display("[TB] reset mid-grant");
    apply_stimulus("t6_grant", 8'h30, 1'b0);
    check_value("t6_id4", 32'(bus.grant_id), 32'd4);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_output("t6_async");
    check_value("t6_async_grant", 32'(bus.grant), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus("t6_after", 8'h30, 1'b0);
    check_value("t6_after_id", 32'(bus.grant_id), 32'd4);
    apply_stimulus("t6_rel", 8'h00, 1'b1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      logic       d;
      r = 8'($urandom);
      if ($urandom_range(3) == 0) r = 8'h00;
      d = ($urandom_range(3) == 0);
      apply_stimulus("rand", r, d);
      if ($urandom_range(60) == 0) async_reset("rand_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
